// File: rtl/tdc_meas_sequencer.sv
// TDC measurement sequencer: start/capture, 2^LOG2_AVG averaging, timeout.
// Optional min/max result tracking when TDC_MINMAX_EN is defined.
module tdc_meas_sequencer #(
  parameter int CNT_W    = 8,
  parameter int LOG2_AVG = 2,
  parameter int TIMEOUT  = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  output logic             start,
  input  logic             ready,
  input  logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] result,
  output logic             result_valid,
  input  logic             result_ack,
  output logic             busy,
  output logic             timeout_err
`ifdef TDC_MINMAX_EN
  ,
  output logic [CNT_W-1:0] result_min,
  output logic [CNT_W-1:0] result_max
`endif
);

  localparam int ACC_W = CNT_W + LOG2_AVG;
  localparam int SMP_W = LOG2_AVG + 1;
  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(1 << LOG2_AVG);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    DONE
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_nxt;
  logic [SMP_W-1:0] smp;
  logic [SMP_W-1:0] smp_nxt;
  logic [15:0]      tmo;
  logic             ready_q;
  logic             rise;

  assign rise    = ready & ~ready_q;
  assign acc_nxt = acc + ACC_W'(count);
  assign smp_nxt = smp + 1'b1;

`ifdef TDC_MINMAX_EN
  logic [CNT_W-1:0] mn;
  logic [CNT_W-1:0] mx;
  logic [CNT_W-1:0] mn_nxt;
  logic [CNT_W-1:0] mx_nxt;

  // first sample of a window seeds both trackers
  always_comb begin
    mn_nxt = mn;
    mx_nxt = mx;
    if (smp == '0 || count < mn) mn_nxt = count;
    if (smp == '0 || count > mx) mx_nxt = count;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      start        <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
      acc          <= '0;
      smp          <= '0;
      tmo          <= '0;
      ready_q      <= 1'b0;
`ifdef TDC_MINMAX_EN
      mn           <= '0;
      mx           <= '0;
      result_min   <= '0;
      result_max   <= '0;
`endif
    end else begin
      ready_q <= ready;
      start   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            state       <= START;
            start       <= 1'b1;
            busy        <= 1'b1;
            acc         <= '0;
            smp         <= '0;
            timeout_err <= 1'b0;
          end
        end
        START: begin
          state <= WAIT;
          tmo   <= '0;
        end
        WAIT: begin
          // a sample on the expiry cycle takes priority over the timeout
          if (rise) begin
            acc <= acc_nxt;
            smp <= smp_nxt;
`ifdef TDC_MINMAX_EN
            mn  <= mn_nxt;
            mx  <= mx_nxt;
`endif
            if (smp_nxt == SMP_LAST) begin
              state        <= DONE;
              result       <= CNT_W'(acc_nxt >> LOG2_AVG);
              result_valid <= 1'b1;
`ifdef TDC_MINMAX_EN
              result_min   <= mn_nxt;
              result_max   <= mx_nxt;
`endif
            end else begin
              state <= START;
              start <= 1'b1;
            end
          end else if (tmo == TMO_LAST) begin
            state       <= IDLE;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
            acc         <= '0;
          end else begin
            tmo <= tmo + 16'd1;
          end
        end
        DONE: begin
          if (result_ack) begin
            state        <= IDLE;
            result_valid <= 1'b0;
            busy         <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_meas_sequencer.sv
// Directed self-checking bench for tdc_meas_sequencer (defaults).
// Define TDC_MINMAX_EN to also check result_min/result_max.
module tb_tdc_meas_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic       start;
  logic       ready = 1'b0;
  logic [7:0] count = '0;
  logic [7:0] result;
  logic       result_valid;
  logic       result_ack = 1'b0;
  logic       busy;
  logic       timeout_err;
`ifdef TDC_MINMAX_EN
  logic [7:0] result_min;
  logic [7:0] result_max;
`endif

  int pass = 0;
  int total = 0;
  int nstarts = 0;

  tdc_meas_sequencer #(
    .CNT_W(8),
    .LOG2_AVG(2),
    .TIMEOUT(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .start(start),
    .ready(ready),
    .count(count),
    .result(result),
    .result_valid(result_valid),
    .result_ack(result_ack),
    .busy(busy),
    .timeout_err(timeout_err)
`ifdef TDC_MINMAX_EN
    ,
    .result_min(result_min),
    .result_max(result_max)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // plays the counter: waits for start, then raises ready after dly cycles
  task automatic do_conv(input logic [7:0] v, input int dly);
    for (int i = 0; i < 16 && start !== 1'b1; i++) step();
    total++;
    if (start !== 1'b1) $display("FAIL conv_start got start=%b want 1", start);
    else begin pass++; nstarts++; end
    step();
    repeat (dly) step();
    ready = 1'b1;
    count = v;
    step();
    ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total++;
    if ({start, result_valid, busy, timeout_err, result} !== 12'h000)
      $display("FAIL reset_outputs got %b %b %b %b %0d want all 0",
               start, result_valid, busy, timeout_err, result);
    else pass++;
    rst = 1'b0;
    repeat (3) step();
    total++;
    if (start !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset_idle got start=%b busy=%b want 0 0", start, busy);
    else pass++;
  endtask

  task automatic test_averaging();
    int bad;
    nstarts = 0;
    req = 1'b1;
    step();
    req = 1'b0;
    total++;
    if (start !== 1'b1 || busy !== 1'b1)
      $display("FAIL req_to_start got start=%b busy=%b want 1 1", start, busy);
    else pass++;
    do_conv(8'd10, 0);
    do_conv(8'd11, 2);
    do_conv(8'd12, 0);
    for (int i = 0; i < 16 && start !== 1'b1; i++) step();
    if (start === 1'b1) nstarts++;
    step();
    ready = 1'b1;
    count = 8'd13;
    total++;
    if (result_valid !== 1'b0)
      $display("FAIL avg_valid_early got %b want 0", result_valid);
    else pass++;
    step();
    ready = 1'b0;
    total++;
    if (result_valid !== 1'b1 || result !== 8'd11)
      $display("FAIL avg_result got v=%b r=%0d want v=1 r=11", result_valid, result);
    else pass++;
    total++;
    if (nstarts !== 4) $display("FAIL avg_starts got %0d want 4", nstarts);
    else pass++;
    bad = 0;
    repeat (20) begin
      step();
      if (result !== 8'd11 || result_valid !== 1'b1 || start !== 1'b0 || busy !== 1'b1) bad++;
    end
    total++;
    if (bad !== 0) $display("FAIL hold_stable got %0d bad cycles want 0", bad);
    else pass++;
    result_ack = 1'b1;
    step();
    result_ack = 1'b0;
    total++;
    if (result_valid !== 1'b0 || busy !== 1'b0 || result !== 8'd11)
      $display("FAIL ack_clear got v=%b busy=%b r=%0d want 0 0 11",
               result_valid, busy, result);
    else pass++;
  endtask

  task automatic test_timeout();
    req = 1'b1;
    step();
    req = 1'b0;
    step();
    repeat (63) step();
    total++;
    if (timeout_err !== 1'b0 || busy !== 1'b1)
      $display("FAIL tmo_early got err=%b busy=%b want 0 1", timeout_err, busy);
    else pass++;
    step();
    total++;
    if (timeout_err !== 1'b1 || busy !== 1'b0 || result !== 8'd11 || result_valid !== 1'b0)
      $display("FAIL tmo_fire got err=%b busy=%b r=%0d v=%b want 1 0 11 0",
               timeout_err, busy, result, result_valid);
    else pass++;
    req = 1'b1;
    step();
    req = 1'b0;
    total++;
    if (timeout_err !== 1'b0 || start !== 1'b1)
      $display("FAIL tmo_clear got err=%b start=%b want 0 1", timeout_err, start);
    else pass++;
    repeat (70) step();
    total++;
    if (busy !== 1'b0 || timeout_err !== 1'b1)
      $display("FAIL tmo_again got busy=%b err=%b want 0 1", busy, timeout_err);
    else pass++;
  endtask

  task automatic test_stuck_ready();
    ready = 1'b1;
    step();
    req = 1'b1;
    step();
    req = 1'b0;
    step();
    repeat (63) step();
    total++;
    if (timeout_err !== 1'b0 || busy !== 1'b1)
      $display("FAIL stuck_early got err=%b busy=%b want 0 1", timeout_err, busy);
    else pass++;
    step();
    total++;
    if (timeout_err !== 1'b1 || busy !== 1'b0 || result !== 8'd11)
      $display("FAIL stuck_fire got err=%b busy=%b r=%0d want 1 0 11",
               timeout_err, busy, result);
    else pass++;
    ready = 1'b0;
    step();
  endtask

  task automatic test_expiry_edge();
    req = 1'b1;
    step();
    req = 1'b0;
    step();
    repeat (63) step();
    ready = 1'b1;
    count = 8'd100;
    step();
    ready = 1'b0;
    total++;
    if (timeout_err !== 1'b0 || busy !== 1'b1 || start !== 1'b1)
      $display("FAIL expiry_edge got err=%b busy=%b start=%b want 0 1 1",
               timeout_err, busy, start);
    else pass++;
    do_conv(8'd101, 0);
    do_conv(8'd102, 1);
    do_conv(8'd103, 0);
    total++;
    if (result_valid !== 1'b1 || result !== 8'd101)
      $display("FAIL expiry_result got v=%b r=%0d want 1 101", result_valid, result);
    else pass++;
    result_ack = 1'b1;
    step();
    result_ack = 1'b0;
  endtask

  task automatic test_minmax();
    req = 1'b1;
    step();
    req = 1'b0;
    do_conv(8'd200, 0);
    do_conv(8'd3, 0);
    do_conv(8'd255, 3);
    do_conv(8'd40, 0);
    total++;
    if (result_valid !== 1'b1 || result !== 8'd124)
      $display("FAIL mm_result got v=%b r=%0d want 1 124", result_valid, result);
    else pass++;
`ifdef TDC_MINMAX_EN
    total++;
    if (result_min !== 8'd3 || result_max !== 8'd255)
      $display("FAIL mm_minmax got min=%0d max=%0d want 3 255", result_min, result_max);
    else pass++;
`endif
    result_ack = 1'b1;
    step();
    result_ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    req = 1'b1;
    do_conv(8'd255, 0);
    do_conv(8'd255, 0);
    do_conv(8'd255, 0);
    do_conv(8'd254, 0);
    total++;
    if (result_valid !== 1'b1 || result !== 8'd254)
      $display("FAIL b2b_max got v=%b r=%0d want 1 254", result_valid, result);
    else pass++;
    result_ack = 1'b1;
    step();
    result_ack = 1'b0;
    total++;
    if (result_valid !== 1'b0 || busy !== 1'b0 || start !== 1'b0)
      $display("FAIL b2b_ack got v=%b busy=%b start=%b want 0 0 0",
               result_valid, busy, start);
    else pass++;
    step();
    total++;
    if (start !== 1'b1 || busy !== 1'b1)
      $display("FAIL b2b_restart got start=%b busy=%b want 1 1", start, busy);
    else pass++;
    req = 1'b0;
    do_conv(8'd7, 0);
    do_conv(8'd0, 0);
    do_conv(8'd0, 0);
    do_conv(8'd0, 0);
    total++;
    if (result_valid !== 1'b1 || result !== 8'd1)
      $display("FAIL b2b_trunc got v=%b r=%0d want 1 1", result_valid, result);
    else pass++;
    result_ack = 1'b1;
    step();
    result_ack = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    int seen;
    req = 1'b1;
    step();
    req = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    total++;
    if ({start, result_valid, busy, timeout_err, result} !== 12'h000)
      $display("FAIL rst_mid got %b %b %b %b %0d want all 0",
               start, result_valid, busy, timeout_err, result);
    else pass++;
    seen = 0;
    repeat (3) begin
      step();
      if (start !== 1'b0) seen++;
    end
    rst = 1'b0;
    repeat (6) begin
      step();
      if (start !== 1'b0 || busy !== 1'b0) seen++;
    end
    total++;
    if (seen !== 0) $display("FAIL rst_no_start got %0d bad cycles want 0", seen);
    else pass++;
  endtask

  initial begin
    test_reset();
    test_averaging();
    test_timeout();
    test_stuck_ready();
    test_expiry_edge();
    test_minmax();
    test_back_to_back();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
